// File: rtl/id_stage_pkg.sv
// Shared decode-stage definitions: opcodes, NOP encoding, register-index width, IF/ID payload.
package id_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned OPCODE_W  = 6;

  typedef enum logic [OPCODE_W-1:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  localparam logic [XLEN-1:0]      NOP_ENC      = 32'h0000_0000;
  localparam logic [REG_IDX_W-1:0] ZERO_REG_IDX = 5'd0;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] instr;
  } ifid_t;

  // rt is a true source only for R-type, beq and sw
  function automatic logic rt_used(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/id_stage_hazard_unit.sv
// Load-use, decode-branch and write-back hazard detection producing the decode stall.
module id_stage_hazard_unit
  import id_stage_pkg::*;
#(
  parameter logic [REG_IDX_W-1:0] ZERO_REG = ZERO_REG_IDX
) (
  input  logic                 ifid_valid,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [REG_IDX_W-1:0] rt,
  input  logic                 idex_mem_read,
  input  logic                 idex_reg_write,
  input  logic [REG_IDX_W-1:0] idex_write_reg,
  input  logic                 exmem_reg_write,
  input  logic [REG_IDX_W-1:0] exmem_write_reg,
  input  logic                 wb_hazard_en,
  input  logic [REG_IDX_W-1:0] wb_write_reg,
  output logic                 stall_c
);

  logic use_rt;
  logic load_use;
  logic branch_hazard;
  logic wb_hazard;

  function automatic logic hit(input logic [REG_IDX_W-1:0] src,
                               input logic                 en,
                               input logic [REG_IDX_W-1:0] dst);
    return en && (src != ZERO_REG) && (src == dst);
  endfunction

  always_comb begin
    use_rt        = rt_used(opcode);
    load_use      = hit(rs, idex_mem_read, idex_write_reg) ||
                    (use_rt && hit(rt, idex_mem_read, idex_write_reg));
    // beq compares in decode, so any in-flight writer of its sources blocks it
    branch_hazard = (opcode == OP_BEQ) &&
                    (hit(rs, idex_reg_write, idex_write_reg)   ||
                     hit(rt, idex_reg_write, idex_write_reg)   ||
                     hit(rs, exmem_reg_write, exmem_write_reg) ||
                     hit(rt, exmem_reg_write, exmem_write_reg));
    wb_hazard     = hit(rs, wb_hazard_en, wb_write_reg) ||
                    (use_rt && hit(rt, wb_hazard_en, wb_write_reg));
    stall_c       = ifid_valid && (load_use || branch_hazard || wb_hazard);
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, 32x32 register file, beq/j resolution and fetch control.
// Define REGFILE_BYPASS_EN to forward same-cycle WB data into reads instead of stalling on WB.
module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [XLEN-1:0]      NOP_INSTR = NOP_ENC,
  parameter logic [REG_IDX_W-1:0] ZERO_REG  = ZERO_REG_IDX
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Instruction_IF,
  input  logic [31:0] PC_Address_next,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic [31:0] address,
  output logic        jump,
  output logic [31:0] j_address,
  input  logic        idex_mem_read,
  input  logic        idex_reg_write,
  input  logic [4:0]  idex_write_reg,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_write_reg,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc_next,
  output logic [31:0] id_read_data1,
  output logic [31:0] id_read_data2,
  output logic [31:0] id_imm_ext,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd
);

  ifid_t                 ifid_q;
  logic [XLEN-1:0]       regs [NUM_REGS];
  logic [OPCODE_W-1:0]   opcode;
  logic                  stall;
  logic                  flush;
  logic                  wb_hazard_en;

  // IF/ID register: stall holds, flush injects a NOP bubble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ifid_q <= '{valid: 1'b0, pc_next: '0, instr: NOP_INSTR};
    end else if (!stall) begin
      if (flush) begin
        ifid_q <= '{valid: 1'b0, pc_next: '0, instr: NOP_INSTR};
      end else begin
        ifid_q <= '{valid: 1'b1, pc_next: PC_Address_next, instr: Instruction_IF};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_reg_write && (wb_write_reg != ZERO_REG)) begin
      regs[wb_write_reg] <= wb_write_data;
    end
  end

  assign id_instruction = ifid_q.instr;
  assign id_pc_next     = ifid_q.pc_next;
  assign opcode         = ifid_q.instr[31:26];
  assign id_rs          = ifid_q.instr[25:21];
  assign id_rt          = ifid_q.instr[20:16];
  assign id_rd          = ifid_q.instr[15:11];
  assign id_imm_ext     = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};

  always_comb begin
    id_read_data1 = regs[id_rs];
    id_read_data2 = regs[id_rt];
`ifdef REGFILE_BYPASS_EN
    if (wb_reg_write && (wb_write_reg == id_rs)) id_read_data1 = wb_write_data;
    if (wb_reg_write && (wb_write_reg == id_rt)) id_read_data2 = wb_write_data;
`endif
    if (id_rs == ZERO_REG) id_read_data1 = '0;
    if (id_rt == ZERO_REG) id_read_data2 = '0;
  end

`ifdef REGFILE_BYPASS_EN
  assign wb_hazard_en = 1'b0;
`else
  assign wb_hazard_en = wb_reg_write;
`endif

  id_stage_hazard_unit #(
    .ZERO_REG (ZERO_REG)
  ) u_hazard (
    .ifid_valid      (ifid_q.valid),
    .opcode          (opcode),
    .rs              (id_rs),
    .rt              (id_rt),
    .idex_mem_read   (idex_mem_read),
    .idex_reg_write  (idex_reg_write),
    .idex_write_reg  (idex_write_reg),
    .exmem_reg_write (exmem_reg_write),
    .exmem_write_reg (exmem_write_reg),
    .wb_hazard_en    (wb_hazard_en),
    .wb_write_reg    (wb_write_reg),
    .stall_c         (stall)
  );

  // Control back to fetch; a stalled decode never redirects
  assign PCWrite   = !stall;
  assign id_valid  = ifid_q.valid && !stall;
  assign PCSrc     = ifid_q.valid && !stall && (opcode == OP_BEQ) &&
                     (id_read_data1 == id_read_data2);
  assign jump      = ifid_q.valid && !stall && (opcode == OP_J);
  assign address   = id_pc_next + (id_imm_ext << 2);
  assign j_address = {id_pc_next[31:28], ifid_q.instr[25:0], 2'b00};
  assign flush     = PCSrc || jump;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: vector table for single-cycle decode plus hand-written pipeline sequences.
module tb_id_stage;

  logic        clock;
  logic        reset;
  logic [31:0] Instruction_IF;
  logic [31:0] PC_Address_next;
  logic        PCWrite;
  logic        PCSrc;
  logic [31:0] address;
  logic        jump;
  logic [31:0] j_address;
  logic        idex_mem_read;
  logic        idex_reg_write;
  logic [4:0]  idex_write_reg;
  logic        exmem_reg_write;
  logic [4:0]  exmem_write_reg;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_next;
  logic [31:0] id_read_data1;
  logic [31:0] id_read_data2;
  logic [31:0] id_imm_ext;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;

  int n_checks = 0;
  int n_fail   = 0;

  id_stage dut (
    .clock           (clock),
    .reset           (reset),
    .Instruction_IF  (Instruction_IF),
    .PC_Address_next (PC_Address_next),
    .PCWrite         (PCWrite),
    .PCSrc           (PCSrc),
    .address         (address),
    .jump            (jump),
    .j_address       (j_address),
    .idex_mem_read   (idex_mem_read),
    .idex_reg_write  (idex_reg_write),
    .idex_write_reg  (idex_write_reg),
    .exmem_reg_write (exmem_reg_write),
    .exmem_write_reg (exmem_write_reg),
    .wb_reg_write    (wb_reg_write),
    .wb_write_reg    (wb_write_reg),
    .wb_write_data   (wb_write_data),
    .id_valid        (id_valid),
    .id_instruction  (id_instruction),
    .id_pc_next      (id_pc_next),
    .id_read_data1   (id_read_data1),
    .id_read_data2   (id_read_data2),
    .id_imm_ext      (id_imm_ext),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mr;
    logic        irw;
    logic [4:0]  iwr;
    logic        erw;
    logic [4:0]  ewr;
    logic        pcw;
    logic        src;
    logic        jmp;
    logic        vld;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_hazards();
    idex_mem_read   = 1'b0;
    idex_reg_write  = 1'b0;
    idex_write_reg  = 5'd0;
    exmem_reg_write = 1'b0;
    exmem_write_reg = 5'd0;
    wb_reg_write    = 1'b0;
    wb_write_reg    = 5'd0;
    wb_write_data   = 32'h0;
  endtask

  // Two edges: the first drains any redirect, the second captures the instruction
  task automatic load(input logic [31:0] instr, input logic [31:0] pc);
    clear_hazards();
    Instruction_IF  = 32'h0;
    PC_Address_next = 32'h0;
    tick();
    Instruction_IF  = instr;
    PC_Address_next = pc;
    tick();
    Instruction_IF  = 32'h0;
    PC_Address_next = 32'h0;
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    clear_hazards();
    Instruction_IF = 32'h0;
    wb_reg_write   = 1'b1;
    wb_write_reg   = r;
    wb_write_data  = d;
    tick();
    clear_hazards();
  endtask

  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [31:0] instr);
    logic [31:0] off;
    off = {{14{instr[15]}}, instr[15:0], 2'b00};
    return pc + off;
  endfunction

  function automatic logic [31:0] j_target(input logic [31:0] pc, input logic [31:0] instr);
    return {pc[31:28], instr[25:0], 2'b00};
  endfunction

  initial begin
    // Register file for the table: $s1=$s2=0x37, $s3=0x99, everything else 0
    vecs[0]  = '{32'h20080020, 32'h0000_0008, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{32'h01098820, 32'h0000_000C, 1'b1, 1'b0, 5'd9,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h01098820, 32'h0000_000C, 1'b1, 1'b0, 5'd17, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{32'h20090004, 32'h0000_0010, 1'b1, 1'b0, 5'd9,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{32'h8C090000, 32'h0000_0014, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'h12320009, 32'h0000_0024, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{32'h1233FFFF, 32'h0000_0100, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'h12320009, 32'h0000_0024, 1'b0, 1'b0, 5'd0,  1'b1, 5'd18, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h12320009, 32'h0000_0024, 1'b0, 1'b1, 5'd17, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h01098820, 32'h0000_000C, 1'b0, 1'b1, 5'd8,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{32'h0800000E, 32'h0000_0048, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{32'h09000000, 32'h1000_0048, 1'b1, 1'b0, 5'd8,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h00000000, 32'h0000_0050, 1'b1, 1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{32'hAD310000, 32'h0000_0054, 1'b1, 1'b0, 5'd17, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{32'h01098820, 32'h0000_000C, 1'b0, 1'b0, 5'd0,  1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    Instruction_IF  = 32'h0;
    PC_Address_next = 32'h0;
    clear_hazards();
    #2;
    chk1 ("rst_pcwrite",  PCWrite, 1'b1);
    chk1 ("rst_pcsrc",    PCSrc, 1'b0);
    chk1 ("rst_jump",     jump, 1'b0);
    chk1 ("rst_valid",    id_valid, 1'b0);
    chk32("rst_address",  address, 32'h0);
    chk32("rst_jaddr",    j_address, 32'h0);
    chk32("rst_instr",    id_instruction, 32'h0);
    chk32("rst_rd1",      id_read_data1, 32'h0);

    tick();
    reset = 1'b0;
    Instruction_IF  = 32'h20080020;
    PC_Address_next = 32'h0000_0004;
    tick();
    chk1 ("first_valid", id_valid, 1'b1);
    chk32("first_rt",    32'(id_rt), 32'd8);
    chk32("first_imm",   id_imm_ext, 32'h20);
    chk32("first_pc",    id_pc_next, 32'h4);

    wb_write(5'd17, 32'h37);
    wb_write(5'd18, 32'h37);
    wb_write(5'd19, 32'h99);
    wb_write(5'd0,  32'hDEAD);
    load({6'b0, 5'd0, 5'd17, 5'd1, 5'd0, 6'h20}, 32'h4);
    chk32("zero_reg_read", id_read_data1, 32'h0);
    chk32("s1_read",       id_read_data2, 32'h37);

    for (int i = 0; i < NVEC; i++) begin
      load(vecs[i].instr, vecs[i].pc);
      idex_mem_read   = vecs[i].mr;
      idex_reg_write  = vecs[i].irw;
      idex_write_reg  = vecs[i].iwr;
      exmem_reg_write = vecs[i].erw;
      exmem_write_reg = vecs[i].ewr;
      #1;
      chk1 ($sformatf("v%0d_pcwrite", i), PCWrite, vecs[i].pcw);
      chk1 ($sformatf("v%0d_pcsrc", i),   PCSrc, vecs[i].src);
      chk1 ($sformatf("v%0d_jump", i),    jump, vecs[i].jmp);
      chk1 ($sformatf("v%0d_valid", i),   id_valid, vecs[i].vld);
      chk32($sformatf("v%0d_imm", i),     id_imm_ext, {{16{vecs[i].instr[15]}}, vecs[i].instr[15:0]});
      chk32($sformatf("v%0d_addr", i),    address, br_target(vecs[i].pc, vecs[i].instr));
      if (vecs[i].jmp)
        chk32($sformatf("v%0d_jaddr", i), j_address, j_target(vecs[i].pc, vecs[i].instr));
    end

    // Load-use: one bubble, IF/ID held, then the next fetch enters
    load(32'h01098820, 32'h0000_000C);
    idex_mem_read  = 1'b1;
    idex_write_reg = 5'd8;
    Instruction_IF = 32'h22220001;
    PC_Address_next = 32'h0000_0010;
    #1;
    chk1("lu_pcwrite_lo", PCWrite, 1'b0);
    chk1("lu_valid_lo",   id_valid, 1'b0);
    tick();
    idex_mem_read  = 1'b0;
    idex_write_reg = 5'd0;
    #1;
    chk32("lu_held",      id_instruction, 32'h01098820);
    chk1 ("lu_pcwrite_hi", PCWrite, 1'b1);
    chk1 ("lu_valid_hi",  id_valid, 1'b1);
    tick();
    chk32("lu_next",      id_instruction, 32'h22220001);

    // beq taken flushes the wrong-path fetch
    load(32'h12320009, 32'h0000_0024);
    chk1 ("beq_pcsrc", PCSrc, 1'b1);
    chk32("beq_addr",  address, 32'h48);
    Instruction_IF = 32'hFFFF_FFFF;
    tick();
    chk32("beq_flush_instr", id_instruction, 32'h0);
    chk1 ("beq_flush_valid", id_valid, 1'b0);
    chk1 ("beq_flush_pcsrc", PCSrc, 1'b0);

    // Branch hazard: writer of $s1 walks EX -> MEM -> WB
    load(32'h12320009, 32'h0000_0024);
    idex_reg_write = 1'b1;
    idex_write_reg = 5'd17;
    #1;
    chk1("bh_ex_pcwrite", PCWrite, 1'b0);
    chk1("bh_ex_pcsrc",   PCSrc, 1'b0);
    tick();
    clear_hazards();
    exmem_reg_write = 1'b1;
    exmem_write_reg = 5'd17;
    #1;
    chk1 ("bh_mem_pcwrite", PCWrite, 1'b0);
    chk1 ("bh_mem_pcsrc",   PCSrc, 1'b0);
    chk32("bh_mem_held",    id_instruction, 32'h12320009);
    tick();
    clear_hazards();
    wb_reg_write  = 1'b1;
    wb_write_reg  = 5'd17;
    wb_write_data = 32'h37;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk1 ("bh_wb_pcwrite", PCWrite, 1'b1);
    chk1 ("bh_wb_pcsrc",   PCSrc, 1'b1);
    chk32("bh_wb_addr",    address, 32'h48);
    tick();
    clear_hazards();
    #1;
    chk1("bh_after_valid", id_valid, 1'b0);
`else
    chk1("bh_wb_pcwrite", PCWrite, 1'b0);
    chk1("bh_wb_pcsrc",   PCSrc, 1'b0);
    tick();
    clear_hazards();
    #1;
    chk1 ("bh_res_pcsrc", PCSrc, 1'b1);
    chk32("bh_res_addr",  address, 32'h48);
`endif

    // Jump redirects and flushes
    load(32'h0800000E, 32'h0000_0048);
    chk1 ("j_jump",  jump, 1'b1);
    chk32("j_addr",  j_address, 32'h38);
    chk1 ("j_pcsrc", PCSrc, 1'b0);
    Instruction_IF = 32'hFFFF_FFFF;
    tick();
    chk32("j_flush_instr", id_instruction, 32'h0);
    chk1 ("j_flush_jump",  jump, 1'b0);

    // Same-cycle WB of the register being read
    load(32'h01098820, 32'h0000_000C);
    wb_reg_write  = 1'b1;
    wb_write_reg  = 5'd8;
    wb_write_data = 32'h5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk32("byp_rd1",     id_read_data1, 32'h5);
    chk1 ("byp_pcwrite", PCWrite, 1'b1);
`else
    chk1("byp_stall_pcwrite", PCWrite, 1'b0);
    chk1("byp_stall_valid",   id_valid, 1'b0);
    tick();
    clear_hazards();
    #1;
    chk32("byp_rd1",     id_read_data1, 32'h5);
    chk1 ("byp_pcwrite", PCWrite, 1'b1);
    chk1 ("byp_valid",   id_valid, 1'b1);
`endif

    // Reset mid-flush
    load(32'h12320009, 32'h0000_0024);
    chk1("rf_pre_pcsrc", PCSrc, 1'b1);
    reset = 1'b1;
    #1;
    chk1 ("rf_pcsrc", PCSrc, 1'b0);
    chk32("rf_addr",  address, 32'h0);
    chk1 ("rf_valid", id_valid, 1'b0);
    tick();
    reset = 1'b0;

    // Reset mid-stall
    load(32'h01098820, 32'h0000_000C);
    idex_mem_read  = 1'b1;
    idex_write_reg = 5'd8;
    #1;
    chk1("rs_pre_pcwrite", PCWrite, 1'b0);
    reset = 1'b1;
    #1;
    chk1 ("rs_pcwrite", PCWrite, 1'b1);
    chk1 ("rs_valid",   id_valid, 1'b0);
    chk32("rs_instr",   id_instruction, 32'h0);
    chk32("rs_pc",      id_pc_next, 32'h0);
    tick();
    reset = 1'b0;
    clear_hazards();

    for (int i = 0; i < 16; i++) begin
      load({6'b0, 5'(i), 5'(i + 16), 5'd0, 5'd0, 6'h20}, 32'h0);
      chk32($sformatf("rst_reg%0d", i),      id_read_data1, 32'h0);
      chk32($sformatf("rst_reg%0d", i + 16), id_read_data2, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage that sits directly downstream of the instruction-fetch stage.
- Holds the IF/ID pipeline register and the 32x32 register file.
- Resolves beq and j in decode, and detects load-use and branch data hazards.
- Drives the fetch controls back upstream (PCWrite, PCSrc, address, jump, j_address) and presents decoded operands to the ID/EX register.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction value loaded into IF/ID on reset or flush.
- ZERO_REG, 5'd0, register index hardwired to zero.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Instruction_IF  in  32  fetched instruction.
- PC_Address_next  in  32  PC+4 of the fetched instruction.
- PCWrite  out  1  0 = fetch holds PC.
- PCSrc  out  1  1 = branch taken.
- address  out  32  branch target.
- jump  out  1  1 = j in decode.
- j_address  out  32  jump target.
- idex_mem_read  in  1  instruction in EX is lw.
- idex_reg_write  in  1  instruction in EX writes a register.
- idex_write_reg  in  5  destination register of the EX instruction.
- exmem_reg_write  in  1  instruction in MEM writes a register.
- exmem_write_reg  in  5  destination register of the MEM instruction.
- wb_reg_write  in  1  write-back enable.
- wb_write_reg  in  5  write-back register index.
- wb_write_data  in  32  write-back data.
- id_valid  out  1  decode outputs carry a real instruction.
- id_instruction  out  32  IF/ID instruction.
- id_pc_next  out  32  IF/ID PC+4.
- id_read_data1  out  32  register file read, rs.
- id_read_data2  out  32  register file read, rt.
- id_imm_ext  out  32  sign-extended imm[15:0].
- id_rs  out  5  instr[25:21].
- id_rt  out  5  instr[20:16].
- id_rd  out  5  instr[15:11].

Behaviour:
- Reset (async):
  - IF/ID instruction = NOP_INSTR, IF/ID PC = 0, IF/ID valid = 0.
  - All 32 registers cleared to 0.
  - Outputs during reset: PCWrite=1, PCSrc=0, jump=0, address=0, j_address=0, id_valid=0.
  - All data outputs 0.
- IF/ID register update, in priority order:
  1. stall: hold.
  2. flush: load NOP_INSTR, valid=0.
  3. otherwise: capture Instruction_IF and PC_Address_next, valid=1.
- Latency: an instruction fetched in cycle N appears on the id_* outputs in cycle N+1. The id_* outputs are combinational from IF/ID and the register file.
- rt is "used" when opcode is 000000, 000100 (beq) or 101011 (sw). rs is always used.
  - A source matches a writer when the source index is nonzero and equal to the writer's destination.
- load_use: idex_mem_read and idex_write_reg matches a used source.
- branch_hazard: decode holds beq, valid, and either:
  - (idex_reg_write and idex_write_reg matches rs/rt), or
  - (exmem_reg_write and exmem_write_reg matches rs/rt).
- stall = IF/ID valid and (load_use or branch_hazard).
- While stall is asserted:
  - PCWrite=0, id_valid=0 (bubble into ID/EX).
  - PCSrc=0, jump=0.
- Branch: beq with valid and no stall; taken when read_data1 == read_data2.
  - PCSrc=1.
  - address = id_pc_next + (imm_ext << 2), computed modulo 2^32 (wrap ignored).
  - address is always driven with the computed target, whether or not the branch is taken.
- Jump: opcode 000010, valid and no stall.
  - jump=1.
  - j_address = {id_pc_next[31:28], instr[25:0], 2'b00}.
- flush = PCSrc or jump. On the next edge IF/ID loads NOP_INSTR, discarding the wrong-path fetch.
  - Stall suppresses flush.
- Register file:
  - Written on the rising edge when wb_reg_write and wb_write_reg != 0.
  - Writes to ZERO_REG are ignored; reads of ZERO_REG return 0.
- Reset asserted mid-stall or mid-flush returns every output to its reset value immediately, with no pending state kept.
- NOP_INSTR decodes as no branch, no jump, no hazard.

Optional Feature:
- REGFILE_BYPASS_EN
- Defined:
  - A read of the register being written by WB in the same cycle returns wb_write_data.
  - WB is excluded from hazard checks.
- Undefined:
  - Reads return the pre-write value.
  - stall additionally asserts when wb_reg_write and wb_write_reg matches a used source, giving one extra bubble.
  - Functional results are identical; cycle counts differ.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_RTYPE=000000, OP_BEQ=000100, OP_J=000010, OP_LW=100011, OP_SW=101011.
  - NOP encoding.
  - Register-index width (5).
- One natural sub-module: hazard_unit, containing the load_use, branch_hazard and stall logic.
- The register file stays inline.

Test Plan:
- Reset: assert reset mid-cycle → PCWrite=1, id_valid=0, all 32 registers read 0; release, fetch 0x20080020 → next cycle id_valid=1, id_rt=8, id_imm_ext=0x20.
- Load-use: decode add $s1,$t0,$t1 while idex_mem_read=1 and idex_write_reg=8 → exactly one cycle with PCWrite=0 and id_valid=0, IF/ID held; then resumes.
- beq taken: $s1=$s2=0x37 (no in-flight writers), beq at PC+4=0x24, imm=9 → PCSrc=1, address=0x48; next cycle IF/ID holds NOP and id_valid=0.
- Branch hazard: beq rs=17 with idex_reg_write=1 and idex_write_reg=17 → stall; once the writer clears EX/MEM, the branch resolves with no PCSrc pulse during the stall.
- j: j 0x0E at id_pc_next=0x48 → jump=1, j_address=0x38, following IF/ID flushed.
- Bypass: WB writes $t0=5 while decode reads rs=$t0 → with REGFILE_BYPASS_EN, id_read_data1=5 and no stall; without it, one stall cycle and then id_read_data1=5.
